// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide
// step per cycle, then a single write-enable pulse toward the register file.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      Read_Data,
  input  logic [WIDTH-1:0]      Read_Data2,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic [WIDTH-1:0]      ALU_WB,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  CNTRL_RS
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [1:0]              r_op;
  logic [REG_ADDR_W-1:0]   r_rd_req;
  logic [REG_ADDR_W-1:0]   r_rd_out;
  logic [CNT_W-1:0]        r_count;
  logic [2*WIDTH-1:0]      r_acc;
  logic [WIDTH-1:0]        r_opnd;
  logic [WIDTH-1:0]        r_alu_wb;

  logic                    w_accept;
  logic                    w_last;
  logic [WIDTH:0]          w_sum;
  logic [WIDTH:0]          w_trial;
  logic                    w_ge;
  logic [WIDTH-1:0]        w_diff;
  logic [2*WIDTH-1:0]      w_acc_next;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_count == CNT_W'(WIDTH - 1));

  // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   r_acc = {partial remainder, dividend/quotient bits}, shifted left.
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_opnd});
  assign w_diff  = w_trial[WIDTH-1:0] - r_opnd;

  always_comb begin
    if (r_op[1] == 1'b0) begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end else begin
      w_acc_next = {(w_ge ? w_diff : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    CNTRL_RS     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        CNTRL_RS     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_rd_req <= '0;
      r_rd_out <= '0;
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_alu_wb <= '0;
    end else if (w_accept) begin
      r_op     <= op;
      r_rd_req <= rd_in;
      r_count  <= '0;
      if (op[1] == 1'b0) begin
        r_acc  <= {{WIDTH{1'b0}}, Read_Data2};
        r_opnd <= Read_Data;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, Read_Data};
        r_opnd <= Read_Data2;
      end
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + 1'b1;
      // Result lands on the edge entering DONE and then holds until the next op.
      if (w_last) begin
        r_alu_wb <= r_op[0] ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
        r_rd_out <= r_rd_req;
      end
    end
  end

  assign ALU_WB = r_alu_wb;
  assign rd     = r_rd_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: the stimulus pushes expected write-backs
// into a scoreboard, and a monitor pops and checks each CNTRL_RS pulse.
module tb_mul_div_unit;

  localparam int WIDTH = 32;
  localparam int RA_W  = 5;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  Read_Data;
  logic [WIDTH-1:0]  Read_Data2;
  logic [RA_W-1:0]   rd_in;
  logic              busy;
  logic [WIDTH-1:0]  ALU_WB;
  logic [RA_W-1:0]   rd;
  logic              CNTRL_RS;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [RA_W-1:0]  rd;
    int               edge_n;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;

  mul_div_unit #(.WIDTH(WIDTH), .REG_ADDR_W(RA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .Read_Data  (Read_Data),
    .Read_Data2 (Read_Data2),
    .rd_in      (rd_in),
    .busy       (busy),
    .ALU_WB     (ALU_WB),
    .rd         (rd),
    .CNTRL_RS   (CNTRL_RS)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  // Monitor: every write-enable pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (CNTRL_RS === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_pulse: CNTRL_RS high with nothing expected, ALU_WB=0x%0h rd=%0d (edge %0d)",
                 ALU_WB, rd, edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("alu_wb", 64'(ALU_WB), 64'(e.res));
        check("rd", 64'(rd), 64'(e.rd));
        check("latency", 64'(edge_cnt), 64'(e.edge_n + WIDTH));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [RA_W-1:0] r, input bit expect_wb, input logic [WIDTH-1:0] res);
    @(negedge clk);
    start      = 1'b1;
    op         = o;
    Read_Data  = a;
    Read_Data2 = b;
    rd_in      = r;
    if (expect_wb) sb.push_back('{res: res, rd: r, edge_n: edge_cnt + 1});
    @(posedge clk);
    #1;
    start      = 1'b0;
    Read_Data  = 32'hDEAD_BEEF;
    Read_Data2 = 32'h1234_5678;
    rd_in      = 5'h1f;
  endtask

  // Waits until every expected write-back has been seen and the unit is idle.
  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: %0d write-backs outstanding, busy=%b", name, sb.size(), busy);
      sb.delete();
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    op         = '0;
    Read_Data  = '0;
    Read_Data2 = '0;
    rd_in      = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wen", 64'(CNTRL_RS), 64'd0);
    check("reset_alu_wb", 64'(ALU_WB), 64'd0);
    check("reset_rd", 64'(rd), 64'd0);

    // Basic multiply, operands scrambled right after accept.
    issue(OP_MUL, 32'd7, 32'd6, 5'd3, 1'b1, 32'd42);
    @(negedge clk);
    check("run_busy", 64'(busy), 64'd1);
    check("run_wen", 64'(CNTRL_RS), 64'd0);
    drain("mul_7x6");
    repeat (3) @(negedge clk);
    check("hold_alu_wb", 64'(ALU_WB), 64'd42);
    check("hold_rd", 64'(rd), 64'd3);

    // Full-scale multiply, high and low halves, issued back to back.
    issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, 32'hFFFF_FFFE);
    drain("mulh_max");
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1, 32'h0000_0001);
    drain("mul_max");

    issue(OP_DIVU, 32'd100, 32'd7, 5'd6, 1'b1, 32'd14);
    drain("divu_100_7");
    issue(OP_REMU, 32'd100, 32'd7, 5'd7, 1'b1, 32'd2);
    drain("remu_100_7");

    // Divide by zero.
    issue(OP_DIVU, 32'd5, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF);
    drain("divu_by0");
    issue(OP_REMU, 32'd5, 32'd0, 5'd9, 1'b1, 32'd5);
    drain("remu_by0");

    // Write-back to x0 still pulses.
    issue(OP_MULH, 32'h8000_0000, 32'd6, 5'd0, 1'b1, 32'd3);
    drain("rd_zero");

    // Start while busy is ignored.
    issue(OP_MUL, 32'd3, 32'd4, 5'd10, 1'b1, 32'd12);
    repeat (9) @(negedge clk);
    start      = 1'b1;
    op         = OP_MUL;
    Read_Data  = 32'd9;
    Read_Data2 = 32'd9;
    rd_in      = 5'd11;
    repeat (2) @(negedge clk);
    start = 1'b0;
    drain("mul_busy_ignore");
    issue(OP_MUL, 32'd9, 32'd9, 5'd11, 1'b1, 32'd81);
    drain("mul_9x9");

    // Reset partway through RUN aborts the operation.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd12, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wen", 64'(CNTRL_RS), 64'd0);
    check("abort_alu_wb", 64'(ALU_WB), 64'd0);
    check("abort_rd", 64'(rd), 64'd0);
    repeat (40) @(negedge clk);
    issue(OP_DIVU, 32'd9, 32'd2, 5'd13, 1'b1, 32'd4);
    drain("divu_after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
